// File: rtl/ef_i2s_tx.sv
// I2S master transmitter: sck/ws generation and MSB-first serialisation of a one-entry sample hold.
// Optional build macro EF_I2S_TX_REPEAT_EN: an underrun slot repeats that channel's last sent sample.
module ef_i2s_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  sck_prescaler,
    input  logic        left_justified,
    input  logic [5:0]  sample_size,
    input  logic [1:0]  channels,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        underrun_clr,
    output logic        sck,
    output logic        ws,
    output logic        sdo,
    output logic        underrun
);

    typedef enum logic {SLOT_L = 1'b0, SLOT_R = 1'b1} slot_t;

    slot_t       slot;
    logic [7:0]  pre_cnt;
    logic [4:0]  bit_ctr;
    logic        primed;
    logic [31:0] hold;
    logic        hold_valid;
    logic [31:0] shifter;
    logic        lj_q;
    logic [5:0]  size_q;
    logic [1:0]  ch_q;
`ifdef EF_I2S_TX_REPEAT_EN
    logic [31:0] last_l;
    logic [31:0] last_r;
`endif

    logic        fall, preamble, active_fall, load;
    logic        lj_eff, slot_en, consume, set_ur, accept;
    logic [5:0]  size_eff, size_n, sh;
    logic [1:0]  ch_eff;
    logic [31:0] aligned, load_word;

    assign s_ready = rst_n & en & ~hold_valid;
    assign accept  = s_valid & s_ready;

    always_comb begin
        fall        = en & (pre_cnt == 8'd0) & sck;
        // In I2S mode the first fall after enable only drops ws, giving the 1-bit lead
        preamble    = fall & ~primed & ~left_justified;
        active_fall = fall & ~preamble;
        load        = active_fall & (bit_ctr == 5'd0);
        lj_eff      = (slot == SLOT_L) ? left_justified : lj_q;
        size_eff    = (slot == SLOT_L) ? sample_size : size_q;
        ch_eff      = (slot == SLOT_L) ? channels : ch_q;
        size_n      = (size_eff == 6'd0) ? 6'd32 : size_eff;
        sh          = 6'd32 - size_n;
        aligned     = hold << sh;
        slot_en     = (slot == SLOT_L) ? ch_eff[1] : ch_eff[0];
        consume     = load & slot_en & hold_valid;
        set_ur      = load & slot_en & ~hold_valid;
        load_word   = '0;
        if (slot_en && hold_valid) begin
            load_word = aligned;
        end else if (slot_en) begin
`ifdef EF_I2S_TX_REPEAT_EN
            load_word = (slot == SLOT_L) ? last_l : last_r;
`else
            load_word = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck        <= 1'b0;
            ws         <= 1'b1;
            sdo        <= 1'b0;
            pre_cnt    <= '0;
            bit_ctr    <= '0;
            slot       <= SLOT_L;
            primed     <= 1'b0;
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            underrun   <= 1'b0;
            lj_q       <= 1'b0;
            size_q     <= '0;
            ch_q       <= '0;
        end else begin
            if (underrun_clr) begin
                underrun <= 1'b0;
            end else if (set_ur) begin
                underrun <= 1'b1;
            end
            if (accept) begin
                hold       <= s_data;
                hold_valid <= 1'b1;
            end else if (consume) begin
                hold_valid <= 1'b0;
            end
            if (!en) begin
                sck     <= 1'b0;
                ws      <= 1'b1;
                sdo     <= 1'b0;
                pre_cnt <= '0;
                bit_ctr <= '0;
                slot    <= SLOT_L;
                primed  <= 1'b0;
                shifter <= '0;
            end else begin
                if (pre_cnt == 8'd0) begin
                    pre_cnt <= sck_prescaler;
                    sck     <= ~sck;
                end else begin
                    pre_cnt <= pre_cnt - 8'd1;
                end
                if (preamble) begin
                    ws     <= 1'b0;
                    primed <= 1'b1;
                end
                if (active_fall) begin
                    primed  <= 1'b1;
                    bit_ctr <= bit_ctr + 5'd1;
                    if (load) begin
                        sdo     <= load_word[31];
                        shifter <= {load_word[30:0], 1'b0};
                        if (slot == SLOT_L) begin
                            lj_q   <= left_justified;
                            size_q <= sample_size;
                            ch_q   <= channels;
                        end
                        if (lj_eff) ws <= (slot == SLOT_R);
                    end else begin
                        sdo     <= shifter[31];
                        shifter <= {shifter[30:0], 1'b0};
                    end
                    if (bit_ctr == 5'd31) begin
                        slot <= (slot == SLOT_L) ? SLOT_R : SLOT_L;
                        if (!lj_eff) ws <= (slot == SLOT_L);
                    end
                end
            end
        end
    end

`ifdef EF_I2S_TX_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_l <= '0;
            last_r <= '0;
        end else if (consume) begin
            if (slot == SLOT_L) last_l <= aligned;
            else                last_r <= aligned;
        end
    end
`endif

endmodule

// File: tb/tb_ef_i2s_tx.sv
// Self-checking bench for ef_i2s_tx: a sck-rise receiver rebuilds slot words and a scoreboard compares them.
module tb_ef_i2s_tx;

    logic        clk, rst_n, en, left_justified, s_valid, s_ready, underrun_clr;
    logic [7:0]  sck_prescaler;
    logic [5:0]  sample_size;
    logic [1:0]  channels;
    logic [31:0] s_data;
    logic        sck, ws, sdo, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic [32:0] rx_q[$];

    // receiver state
    logic        rx_lj = 1'b0;
    logic        sck_d = 1'b0;
    logic        ws_prev = 1'b1;
    logic        cur_slot = 1'b0;
    logic [31:0] rx_word = '0;
    int          bitpos = 99;
    int          cyc = 0;
    int          last_rise = 0;
    int          period = 0;
    int          hs_cnt = 0;

    ef_i2s_tx dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(sck_prescaler),
        .left_justified(left_justified), .sample_size(sample_size), .channels(channels),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .underrun_clr(underrun_clr),
        .sck(sck), .ws(ws), .sdo(sdo), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bit changed;
        cyc++;
        if (s_valid && s_ready) hs_cnt++;
        if (!rst_n || !en) begin
            bitpos  = 99;
            ws_prev = 1'b1;
            sck_d   = 1'b0;
        end else begin
            if (sck && !sck_d) begin
                changed = (ws !== ws_prev);
                if (changed && rx_lj) begin bitpos = 0; cur_slot = ws; end
                if (bitpos < 32) begin
                    rx_word[31-bitpos] = sdo;
                    if (bitpos == 31) rx_q.push_back({cur_slot, rx_word});
                    bitpos++;
                end
                if (changed && !rx_lj) begin bitpos = 0; cur_slot = ws; end
                ws_prev   = ws;
                period    = cyc - last_rise;
                last_rise = cyc;
            end
            sck_d = sck;
        end
    end

    function automatic logic [31:0] exp_align(input logic [31:0] d, input logic [5:0] sz);
        int n;
        n = (sz == 6'd0) ? 32 : int'(sz);
        return d << (32 - n);
    endfunction

    task automatic cfg(input logic lj, input logic [5:0] sz, input logic [1:0] ch);
        left_justified = lj;
        rx_lj          = lj;
        sample_size    = sz;
        channels       = ch;
    endtask

    task automatic push(input logic [31:0] d, input logic sl, input logic [32:0] word);
        int t = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && t < 3000) begin @(negedge clk); t++; end
        if (!s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        exp_q.push_back({sl, word[31:0]});
    endtask

    task automatic get_word(output logic [32:0] w, output bit ok);
        int t = 0;
        while (rx_q.size() == 0 && t < 3000) begin @(negedge clk); t++; end
        ok = (rx_q.size() != 0);
        w  = ok ? rx_q.pop_front() : 33'h0;
    endtask

    task automatic stop();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        n_checks++; if (sck !== 1'b0)     begin n_fail++; $display("FAIL reset_sck: got %b required 0", sck); end
        n_checks++; if (ws !== 1'b1)      begin n_fail++; $display("FAIL reset_ws: got %b required 1", ws); end
        n_checks++; if (sdo !== 1'b0)     begin n_fail++; $display("FAIL reset_sdo: got %b required 0", sdo); end
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b required 0", s_ready); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b required 0", underrun); end
    endtask

    task automatic test_stereo_i2s();
        logic [32:0] got, exp; bit ok;
        cfg(1'b0, 6'd32, 2'b11);
        @(negedge clk); en = 1'b1;
        push(32'hA5A5_0001, 1'b0, {1'b0, exp_align(32'hA5A5_0001, 6'd32)});
        push(32'h8000_00FF, 1'b1, {1'b0, exp_align(32'h8000_00FF, 6'd32)});
        for (int i = 0; i < 2; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL i2s_word%0d: got %h required %h", i, got, exp); end
        end
        n_checks++; if (period !== 4)      begin n_fail++; $display("FAIL i2s_sck_period: got %0d required 4", period); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL i2s_underrun: got %b required 0", underrun); end
        stop();
    endtask

    task automatic test_left_justified();
        logic [32:0] got, exp; bit ok;
        cfg(1'b1, 6'd16, 2'b11);
        @(negedge clk); en = 1'b1;
        push(32'h0000_1234, 1'b0, {1'b0, exp_align(32'h0000_1234, 6'd16)});
        push(32'h0000_ABCD, 1'b1, {1'b0, exp_align(32'h0000_ABCD, 6'd16)});
        for (int i = 0; i < 2; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL lj_word%0d: got %h required %h", i, got, exp); end
        end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL lj_underrun: got %b required 0", underrun); end
        stop();
    endtask

    task automatic test_left_only();
        logic [32:0] got, exp; bit ok;
        cfg(1'b0, 6'd8, 2'b10);
        hs_cnt = 0;
        @(negedge clk); en = 1'b1;
        push(32'h0000_00C3, 1'b0, {1'b0, exp_align(32'h0000_00C3, 6'd8)});
        exp_q.push_back({1'b1, 32'h0});
        push(32'h0000_005A, 1'b0, {1'b0, exp_align(32'h0000_005A, 6'd8)});
        exp_q.push_back({1'b1, 32'h0});
        for (int i = 0; i < 4; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL left_only_word%0d: got %h required %h", i, got, exp); end
        end
        n_checks++; if (hs_cnt !== 2)      begin n_fail++; $display("FAIL left_only_handshakes: got %0d required 2", hs_cnt); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL left_only_underrun: got %b required 0", underrun); end
        stop();
    endtask

    task automatic test_underrun();
        logic [32:0] got, exp; bit ok;
        logic [31:0] rep;
        cfg(1'b0, 6'd32, 2'b11);
        @(negedge clk); en = 1'b1;
        push(32'h1111_2222, 1'b0, {1'b0, 32'h1111_2222});
        push(32'h3333_4444, 1'b1, {1'b0, 32'h3333_4444});
        push(32'h5555_6666, 1'b0, {1'b0, 32'h5555_6666});
`ifdef EF_I2S_TX_REPEAT_EN
        rep = 32'h3333_4444;
`else
        rep = 32'h0;
`endif
        exp_q.push_back({1'b1, rep});
        for (int i = 0; i < 4; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL underrun_word%0d: got %h required %h", i, got, exp); end
        end
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b required 1", underrun); end
        stop();
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clr: got %b required 0", underrun); end
    endtask

    task automatic test_disable_midframe();
        logic [32:0] got, exp; bit ok;
        int t = 0;
        cfg(1'b0, 6'd32, 2'b11);
        @(negedge clk); en = 1'b1;
        push(32'hCAFE_0001, 1'b0, {1'b0, 32'hCAFE_0001});
        push(32'hCAFE_0002, 1'b1, {1'b0, 32'hCAFE_0002});
        push(32'hCAFE_0003, 1'b0, {1'b0, 32'hCAFE_0003});
        get_word(got, ok);
        exp = exp_q.pop_front();
        n_checks++;
        if (!ok || got !== exp) begin n_fail++; $display("FAIL dis_first_word: got %h required %h", got, exp); end
        while (!(cur_slot == 1'b1 && bitpos == 10) && t < 3000) begin @(negedge clk); t++; end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sck, ws, sdo, s_ready} !== 4'b0100) begin
            n_fail++; $display("FAIL dis_idle: sck/ws/sdo/s_ready got %b required 0100", {sck, ws, sdo, s_ready});
        end
        repeat (20) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL dis_hold_kept: s_ready got %b required 0", s_ready); end
        void'(exp_q.pop_front());
        push(32'hCAFE_0004, 1'b1, {1'b0, 32'hCAFE_0004});
        for (int i = 0; i < 2; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL dis_restart_word%0d: got %h required %h", i, got, exp); end
        end
        stop();
    endtask

    task automatic test_mute();
        logic [32:0] got, exp; bit ok;
        cfg(1'b0, 6'd32, 2'b00);
        exp_q.push_back({1'b0, 32'h0});
        exp_q.push_back({1'b1, 32'h0});
        @(negedge clk); en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            get_word(got, ok);
            exp = exp_q.pop_front();
            n_checks++;
            if (!ok || got !== exp) begin n_fail++; $display("FAIL mute_word%0d: got %h required %h", i, got, exp); end
        end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL mute_underrun: got %b required 0", underrun); end
        stop();
    endtask

    task automatic test_async_reset();
        int t = 0;
        cfg(1'b0, 6'd32, 2'b11);
        @(negedge clk); en = 1'b1;
        while (underrun !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sck, ws, sdo, s_ready, underrun} !== 5'b01000) begin
            n_fail++; $display("FAIL async_reset: sck/ws/sdo/s_ready/underrun got %b required 01000",
                               {sck, ws, sdo, s_ready, underrun});
        end
        @(negedge clk); en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sck_prescaler = 8'd1; left_justified = 1'b0;
        sample_size = 6'd32; channels = 2'b11; s_data = '0; s_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_stereo_i2s();
        test_left_justified();
        test_left_only();
        test_underrun();
        test_disable_midframe();
        test_mute();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
